// File: rtl/constants.sv
// Core-wide architectural constants shared by the RV64 memory-side blocks.
package constants;
    localparam int XLEN = 64;
endpackage

// File: rtl/mem_pkg.sv
// Types and helpers for the data memory: access sizes, controller states,
// response pipeline stage and byte-lane helpers.
package mem_pkg;
    import constants::*;

    typedef enum logic [1:0] {MEM_B, MEM_H, MEM_W, MEM_D} mem_size_t;

    typedef enum logic {ST_CLEAR, ST_READY} ctrl_state_t;

    typedef struct packed {
        logic            valid;
        logic            misalign;
        logic [2:0]      addr_lo;
        mem_size_t       size;
        logic            uext;
        logic [XLEN-1:0] word;
    } resp_stage_t;

    function automatic logic [3:0] size_bytes(mem_size_t s);
        return 4'd1 << s;
    endfunction

    function automatic logic [7:0] byte_mask(mem_size_t s, logic [2:0] lo);
        logic [8:0] m;
        m = (9'd1 << size_bytes(s)) - 9'd1;
        return m[7:0] << lo;
    endfunction

    function automatic logic misaligned(mem_size_t s, logic [2:0] lo);
        case (s)
            MEM_H:   return lo[0];
            MEM_W:   return |lo[1:0];
            MEM_D:   return |lo;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/load_extend.sv
// Combinational load alignment: shifts the addressed bytes down to bit 0,
// truncates to the access size and sign- or zero-extends to XLEN.
module load_extend
    import constants::*;
    import mem_pkg::*;
(
    input  logic [XLEN-1:0] word,
    input  logic [2:0]      addr_lo,
    input  mem_size_t       size,
    input  logic            uext,
    output logic [XLEN-1:0] data
);
    logic [XLEN-1:0] sh;

    always_comb begin
        sh   = word >> {addr_lo, 3'b000};
        data = sh;
        case (size)
            MEM_B:   data = uext ? {{(XLEN-8){1'b0}}, sh[7:0]}
                                 : {{(XLEN-8){sh[7]}}, sh[7:0]};
            MEM_H:   data = uext ? {{(XLEN-16){1'b0}}, sh[15:0]}
                                 : {{(XLEN-16){sh[15]}}, sh[15:0]};
            MEM_W:   data = uext ? {{(XLEN-32){1'b0}}, sh[31:0]}
                                 : {{(XLEN-32){sh[31]}}, sh[31:0]};
            default: data = sh;
        endcase
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// Byte-addressed XLEN-wide data memory with B/H/W/D access, misalignment
// detection, a post-reset clear sweep and a fixed-latency response pipeline.
module data_memory_ctrl
    import constants::*;
    import mem_pkg::*;
#(
    parameter int ADDR_BITS      = 12,
    parameter int READ_LATENCY   = 1,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic            req_we,
    input  logic [1:0]      req_size,
    input  logic            req_unsigned,
    input  logic [XLEN-1:0] req_addr,
    input  logic [XLEN-1:0] req_wdata,
    output logic            resp_valid,
    output logic [XLEN-1:0] resp_rdata,
    output logic            resp_misalign
);
    localparam int IW    = ADDR_BITS - 3;
    localparam int DEPTH = 2 ** IW;

    logic [XLEN-1:0] mem [DEPTH];

    ctrl_state_t state, state_next;
    logic [IW-1:0] clr_idx;
    logic          clr_we;
    logic          ready_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            if (CLEAR_ON_RESET) state <= ST_CLEAR;
            else                state <= ST_READY;
            clr_idx <= '0;
            ready_q <= 1'b0;
        end else begin
            state   <= state_next;
            ready_q <= (state_next == ST_READY);
            if (state == ST_CLEAR) clr_idx <= clr_idx + 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        clr_we     = 1'b0;
        case (state)
            ST_CLEAR: begin
                clr_we = 1'b1;
                if (clr_idx == IW'(DEPTH - 1)) state_next = ST_READY;
            end
            default: state_next = ST_READY;
        endcase
    end

    assign req_ready = ready_q;

    // Request decode; address bits above ADDR_BITS-1 alias onto the array.
    logic            accept, mis, do_store;
    mem_size_t       size;
    logic [2:0]      lo;
    logic [IW-1:0]   idx;
    logic [7:0]      be;
    logic [XLEN-1:0] wlane;
    logic            unused_addr;

    assign accept      = req_valid & req_ready;
    assign size        = mem_size_t'(req_size);
    assign lo          = req_addr[2:0];
    assign idx         = req_addr[ADDR_BITS-1:3];
    assign mis         = misaligned(size, lo);
    assign do_store    = accept & req_we & ~mis;
    assign be          = byte_mask(size, lo);
    assign wlane       = req_wdata << {lo, 3'b000};
    assign unused_addr = ^req_addr[XLEN-1:ADDR_BITS];

    always_ff @(posedge clk) begin
        if (clr_we) begin
            mem[clr_idx] <= '0;
        end else if (do_store) begin
            for (int b = 0; b < 8; b++)
                if (be[b]) mem[idx][8*b +: 8] <= wlane[8*b +: 8];
        end
    end

    // Stores and misaligned accesses carry a zero word, so they extend to 0.
    resp_stage_t cur, last;

    always_comb begin
        cur.valid    = accept;
        cur.misalign = mis;
        cur.addr_lo  = lo;
        cur.size     = size;
        cur.uext     = req_unsigned;
        cur.word     = (accept && !req_we && !mis) ? mem[idx] : '0;
    end

    if (READ_LATENCY == 1) begin : g_direct
        assign last = cur;
    end else begin : g_pipe
        resp_stage_t pipe [READ_LATENCY-1];

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int k = 0; k < READ_LATENCY - 1; k++) pipe[k] <= '0;
            end else begin
                pipe[0] <= cur;
                for (int k = 1; k < READ_LATENCY - 1; k++) pipe[k] <= pipe[k-1];
            end
        end

        assign last = pipe[READ_LATENCY-2];
    end

    logic [XLEN-1:0] ext_data;

    load_extend u_ext (
        .word    (last.word),
        .addr_lo (last.addr_lo),
        .size    (last.size),
        .uext    (last.uext),
        .data    (ext_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_misalign <= 1'b0;
        end else begin
            resp_valid    <= last.valid;
            resp_rdata    <= last.valid ? ext_data : '0;
            resp_misalign <= last.valid & last.misalign;
        end
    end
endmodule

// File: tb/tb_data_memory_ctrl.sv
// Scoreboard bench for data_memory_ctrl: byte-array reference model, directed
// cases plus randomized traffic, responses checked by an independent monitor.
module tb_data_memory_ctrl;
    localparam int AB    = 6;
    localparam int LAT   = 3;
    localparam int BYTES = 2 ** AB;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = '0;
    logic        req_unsigned = 1'b0;
    logic [63:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic        resp_misalign;

    data_memory_ctrl #(.ADDR_BITS(AB), .READ_LATENCY(LAT), .CLEAR_ON_RESET(1'b1)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_we        (req_we),
        .req_size      (req_size),
        .req_unsigned  (req_unsigned),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .resp_valid    (resp_valid),
        .resp_rdata    (resp_rdata),
        .resp_misalign (resp_misalign)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] rdata;
        logic        mis;
        int          cyc;
    } exp_t;

    exp_t       sbq [$];
    exp_t       me;
    logic [7:0] ref_mem [BYTES];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s got %h want %h (t=%0t)", nm, act, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (resp_valid) begin
            if (sbq.size() == 0) begin
                chk("unexpected_resp_valid", 64'd1, 64'd0);
            end else begin
                me = sbq.pop_front();
                chk("rdata", resp_rdata, me.rdata);
                chk("misalign", 64'(resp_misalign), 64'(me.mis));
                chk("resp_cycle", 64'(cyc), 64'(me.cyc));
            end
        end
    end

    // Called on a falling edge; returns on the falling edge after acceptance.
    task automatic issue(input bit we, input int sz, input bit uns,
                         input logic [63:0] addr, input logic [63:0] wd);
        int   n, a, w;
        exp_t e;
        logic [63:0] v;
        n = 1 << sz;
        a = int'(addr[AB-1:0]);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = 2'(sz);
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wd;
        w = 0;
        while (!req_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        if (!req_ready) begin
            chk("req_ready_timeout", 64'd0, 64'd1);
            req_valid = 1'b0;
            return;
        end
        e.mis   = (a % n) != 0;
        e.rdata = '0;
        e.cyc   = cyc + LAT;
        if (!e.mis) begin
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[a+i] = wd[8*i +: 8];
            end else begin
                v = '0;
                for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a+i]) << (8*i));
                if (!uns && n < 8 && v[8*n-1]) v = v | ~((64'd1 << (8*n)) - 64'd1);
                e.rdata = v;
            end
        end
        sbq.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    // Holds reset, checks reset outputs, then measures the clear sweep while
    // presenting a store that must be ignored.
    task automatic do_reset();
        int n;
        rst = 1'b1;
        req_valid = 1'b0;
        sbq.delete();
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_rdata", resp_rdata, 64'd0);
        chk("rst_resp_misalign", 64'(resp_misalign), 64'd0);
        for (int i = 0; i < BYTES; i++) ref_mem[i] = 8'h00;
        rst          = 1'b0;
        req_valid    = 1'b1;
        req_we       = 1'b1;
        req_size     = 2'd3;
        req_addr     = 64'h0;
        req_wdata    = 64'hDEAD_BEEF_0BAD_F00D;
        n = 0;
        while (!req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        chk("clear_ready_low_cycles", 64'(n), 64'd8);
    endtask

    task automatic drain();
        int w;
        w = 0;
        while (sbq.size() != 0 && w < 40) begin
            @(negedge clk);
            w++;
        end
        chk("drain_pending", 64'(sbq.size()), 64'd0);
        repeat (4) @(negedge clk);
    endtask

    initial begin
        #1;
        do_reset();

        for (int i = 0; i < 8; i++) issue(0, 3, 0, 64'(8 * i), '0);

        issue(1, 3, 0, 64'h10, 64'h1122334455667788);
        issue(0, 0, 0, 64'h13, '0);
        issue(0, 2, 1, 64'h14, '0);

        issue(1, 0, 0, 64'h21, 64'hFF);
        issue(0, 1, 0, 64'h20, '0);
        issue(0, 1, 1, 64'h20, '0);

        issue(1, 2, 0, 64'h22, 64'hCAFEBABE);
        issue(0, 3, 0, 64'h20, '0);
        issue(0, 1, 0, 64'h21, '0);

        issue(1, 3, 0, 64'h38, 64'hA5A5_0123_4567_89AB);
        issue(0, 3, 0, 64'h38, '0);
        issue(0, 3, 0, 64'h78, '0);
        issue(0, 2, 0, 64'hFFFF_0000_0000_003C, '0);
        drain();

        for (int i = 0; i < 300; i++) begin
            issue(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), {$urandom, $urandom}, {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        issue(1, 3, 0, 64'h40, 64'h0F0E_0D0C_0B0A_0908);
        issue(0, 3, 0, 64'h40, '0);
        drain();

        issue(1, 3, 0, 64'h40, 64'h7777_6666_5555_4444);
        issue(0, 3, 0, 64'h40, '0);
        do_reset();
        issue(0, 3, 0, 64'h00, '0);
        issue(0, 3, 0, 64'h38, '0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got 1 want 0");
        $fatal(1, "timeout");
    end
endmodule
